top4_peak_finder: RTL and testbench
===================================

TOP4_PEAK_FINDER -- requirements
Module: top4_peak_finder

Interface
REQ-001 SHALL have parameter logN, default 9, meaning log2 of FFT length N (N = 1 << logN).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  level; a scan begins when sampled high in IDLE.
REQ-005 SHALL have port rd_addr  output  logN  FFT result RAM read address.
REQ-006 SHALL have port rd_data  input  32  RAM word, {re[31:16], im[15:0]}, signed two's complement, valid one cycle after rd_addr.
REQ-007 SHALL have port busy  output  1  high in SCAN and DRAIN.
REQ-008 SHALL have port done  output  1  level; high from scan completion until next accepted start.
REQ-009 SHALL have ports peak0_bin..peak3_bin  output  logN each  bin indices, peak0 largest.
REQ-010 SHALL have ports peak0_mag..peak3_mag  output  32 each  unsigned magnitude of the matching bin.
REQ-011 SHALL have port peak_valid  output  4  bit n high when slot n holds a bin.

Function
REQ-012 SHALL implement states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN and DONE->SCAN on start high; SCAN->DRAIN after last address issued; DRAIN->DONE after the last insertion.
REQ-013 SHALL scan bins 1 through N/2-1 in ascending order, one address per cycle; bin 0 (DC) and bins N/2..N-1 are never read.
REQ-014 SHALL drive rd_addr as a register: value 1 in the first SCAN cycle, incrementing by 1 each cycle, held at 0 outside SCAN.
REQ-015 SHALL compute mag = re*re + im*im as a 32-bit unsigned value (no overflow possible; -32768 squared twice = 2^31), registered one cycle after rd_data is valid.
REQ-016 SHALL insert each registered mag into a sorted 4-entry list one cycle later, shifting lower entries down; last entry is discarded on overflow.
REQ-017 SHALL insert a candidate above an existing entry only when strictly greater; on equal magnitudes the lower (earlier) bin keeps the higher slot.
REQ-018 SHALL never insert a bin with mag == 0; such bins leave peak_valid unchanged.
REQ-019 SHALL fill empty slots (peak_valid bit low) before comparing against valid ones; peak_valid fills from bit 0 upward, contiguous.
REQ-020 SHALL clear all peak outputs, peak_valid and done in the cycle a start is accepted, before the first insertion.
REQ-021 SHALL assert done and present final peak outputs at the (N/2+1)th rising edge after the edge that sampled start (edge 257 for logN = 9).
REQ-022 SHALL ignore start while busy is high; a held-high start in DONE restarts the scan on the next edge.
REQ-023 SHALL keep peak outputs stable in DONE and IDLE.

Reset
REQ-024 SHALL, on reset high, immediately enter IDLE and drive rd_addr=0, busy=0, done=0, peak_valid=0, all peak_bin=0, all peak_mag=0, regardless of state.
REQ-025 SHALL, on reset deassertion mid-scan, remain in IDLE; no partial results survive and a new start is required.

Verification
REQ-026 Single tone: RAM bin 10 = {16'h4000,16'h0000}, all others 0, start pulse -> done at edge 257, peak0_bin=10, peak0_mag=32'h1000_0000, peak_valid=4'b0001.
REQ-027 Five tones: bins 3,50,100,200,250 with re=100,500,300,400,200, im=0 -> peak0..3 bins = 50,200,100,250, mags 250000,160000,90000,40000, peak_valid=4'b1111.
REQ-028 Tie and excluded bins: bins 20 and 40 both re=1000, bin 0 and bin 300 re=32767 -> peak0_bin=20, peak1_bin=40, DC and bin 300 absent, peak_valid=4'b0011.
REQ-029 All-zero RAM -> done at edge 257, peak_valid=4'b0000, all bins and mags 0.
REQ-030 Reset at edge 100 of a scan, released 3 cycles later -> IDLE, busy=0, done=0, peak_valid=0; rd_addr stays 0 until next start.
REQ-031 Start toggled high during SCAN at edges 10 and 150 -> no restart, done still at edge 257 with results identical to REQ-027 run.

Source files
------------

// File: rtl/top4_peak_finder.sv
// rtl/top4_peak_finder.sv - scans the lower FFT half-spectrum and keeps the four largest magnitude bins
module top4_peak_finder #(
    parameter int logN = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [logN-1:0] rd_addr,
    input  logic [31:0]     rd_data,
    output logic            busy,
    output logic            done,
    output logic [logN-1:0] peak0_bin,
    output logic [logN-1:0] peak1_bin,
    output logic [logN-1:0] peak2_bin,
    output logic [logN-1:0] peak3_bin,
    output logic [31:0]     peak0_mag,
    output logic [31:0]     peak1_mag,
    output logic [31:0]     peak2_mag,
    output logic [31:0]     peak3_mag,
    output logic [3:0]      peak_valid
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    localparam logic [logN-1:0] LAST_BIN = logN'((1 << (logN - 1)) - 1);

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            data_v;
    logic            mag_v;
    logic [logN-1:0] data_bin;
    logic [logN-1:0] mag_bin;
    logic [31:0]     mag;
    logic [31:0]     mag_next;
    logic [logN-1:0] bin_q [4];
    logic [31:0]     mag_q [4];
    logic [3:0]      gt;
    logic            ins;
    logic signed [31:0] re_x;
    logic signed [31:0] im_x;

    assign accept = start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_SCAN;
            S_SCAN:  if (rd_addr == LAST_BIN) state_next = S_DRAIN;
            // last bin has reached the mag register and nothing is behind it
            S_DRAIN: if (mag_v && !data_v) state_next = S_DONE;
            S_DONE:  if (start) state_next = S_SCAN;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_SCAN) || (state == S_DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
        end else if (accept) begin
            rd_addr <= logN'(1);
        end else if (state == S_SCAN && rd_addr != LAST_BIN) begin
            rd_addr <= rd_addr + logN'(1);
        end else begin
            rd_addr <= '0;
        end
    end

    assign re_x     = {{16{rd_data[31]}}, rd_data[31:16]};
    assign im_x     = {{16{rd_data[15]}}, rd_data[15:0]};
    assign mag_next = 32'(re_x * re_x) + 32'(im_x * im_x);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_v   <= 1'b0;
            data_bin <= '0;
            mag_v    <= 1'b0;
            mag_bin  <= '0;
            mag      <= '0;
        end else begin
            data_v   <= (state == S_SCAN);
            data_bin <= rd_addr;
            mag_v    <= data_v;
            mag_bin  <= data_bin;
            mag      <= mag_next;
        end
    end

    // The list is sorted and filled contiguously, so gt is a thermometer code
    // whose lowest set bit is the insertion slot; ties fall below existing entries.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            gt[i] = !peak_valid[i] || (mag > mag_q[i]);
        end
        ins = mag_v && (mag != 32'd0) && gt[3];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                bin_q[i] <= '0;
                mag_q[i] <= '0;
            end
            peak_valid <= 4'b0000;
            done       <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < 4; i++) begin
                bin_q[i] <= '0;
                mag_q[i] <= '0;
            end
            peak_valid <= 4'b0000;
            done       <= 1'b0;
        end else begin
            if (ins) begin
                if (gt[0]) begin
                    bin_q[0] <= mag_bin;
                    mag_q[0] <= mag;
                end
                for (int i = 1; i < 4; i++) begin
                    if (gt[i]) begin
                        bin_q[i] <= gt[i-1] ? bin_q[i-1] : mag_bin;
                        mag_q[i] <= gt[i-1] ? mag_q[i-1] : mag;
                    end
                end
                peak_valid <= {peak_valid[2:0], 1'b1};
            end
            if (state == S_DRAIN && state_next == S_DONE) done <= 1'b1;
        end
    end

    assign peak0_bin = bin_q[0];
    assign peak1_bin = bin_q[1];
    assign peak2_bin = bin_q[2];
    assign peak3_bin = bin_q[3];
    assign peak0_mag = mag_q[0];
    assign peak1_mag = mag_q[1];
    assign peak2_mag = mag_q[2];
    assign peak3_mag = mag_q[3];

endmodule

// File: tb/tb_top4_peak_finder.sv
// tb/tb_top4_peak_finder.sv - randomized and directed bench for top4_peak_finder against a top-4 selection model
module tb_top4_peak_finder;

    localparam int LOGN = 9;
    localparam int HALF = 1 << (LOGN - 1);
    localparam int DONE_EDGE = HALF + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [LOGN-1:0] rd_addr;
    logic [31:0]     rd_data = 32'd0;
    logic            busy;
    logic            done;
    logic [LOGN-1:0] peak0_bin, peak1_bin, peak2_bin, peak3_bin;
    logic [31:0]     peak0_mag, peak1_mag, peak2_mag, peak3_mag;
    logic [3:0]      peak_valid;

    top4_peak_finder #(.logN(LOGN)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done),
        .peak0_bin(peak0_bin), .peak1_bin(peak1_bin),
        .peak2_bin(peak2_bin), .peak3_bin(peak3_bin),
        .peak0_mag(peak0_mag), .peak1_mag(peak1_mag),
        .peak2_mag(peak2_mag), .peak3_mag(peak3_mag),
        .peak_valid(peak_valid)
    );

    always #5 clk = ~clk;

    logic [31:0] mem  [1 << LOGN];
    logic [31:0] snap [1 << LOGN];

    always @(posedge clk) rd_data <= mem[rd_addr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mag_of(input logic [31:0] w);
        longint re, im;
        re = longint'($signed(w[31:16]));
        im = longint'($signed(w[15:0]));
        return 32'(re * re + im * im);
    endfunction

    // model: edges since accepted start, and the RAM contents frozen at that start
    bit m_run = 0;
    int mcyc  = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0;
            mcyc  = 0;
        end else if (start && (!m_run || mcyc >= DONE_EDGE)) begin
            m_run = 1;
            mcyc  = 0;
            snap  = mem;
        end else if (m_run) begin
            mcyc++;
        end
    end

    int          exp_bin [4];
    logic [31:0] exp_mag [4];
    logic [3:0]  exp_valid;

    // top four by selection over bins 1..upto; strict > keeps the lowest bin on ties
    task automatic model_top(input int upto);
        for (int k = 0; k < 4; k++) begin
            exp_bin[k] = 0;
            exp_mag[k] = 0;
        end
        exp_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int best = 0;
            logic [31:0] bm = 0;
            for (int b = 1; b <= upto; b++) begin
                logic [31:0] m = mag_of(snap[b]);
                bit taken = 0;
                for (int j = 0; j < k; j++) if (exp_bin[j] == b) taken = 1;
                if (!taken && m > bm) begin
                    best = b;
                    bm   = m;
                end
            end
            if (best > 0) begin
                exp_bin[k]   = best;
                exp_mag[k]   = bm;
                exp_valid[k] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        int upto;
        int ea;
        bit eb, ed;
        if (reset || !m_run) begin
            upto = 0; ea = 0; eb = 0; ed = 0;
        end else begin
            upto = mcyc - 2;
            if (upto < 0) upto = 0;
            if (upto > HALF - 1) upto = HALF - 1;
            ea = (mcyc <= HALF - 2) ? mcyc + 1 : 0;
            eb = (mcyc <= HALF);
            ed = (mcyc >= DONE_EDGE);
        end
        model_top(upto);
        check("rd_addr", rd_addr, ea);
        check("busy", busy, eb);
        check("done", done, ed);
        check("peak_valid", peak_valid, exp_valid);
        check("peak0_bin", peak0_bin, exp_bin[0]);
        check("peak1_bin", peak1_bin, exp_bin[1]);
        check("peak2_bin", peak2_bin, exp_bin[2]);
        check("peak3_bin", peak3_bin, exp_bin[3]);
        check("peak0_mag", peak0_mag, exp_mag[0]);
        check("peak1_mag", peak1_mag, exp_mag[1]);
        check("peak2_mag", peak2_mag, exp_mag[2]);
        check("peak3_mag", peak3_mag, exp_mag[3]);
    end

    task automatic clear_mem();
        for (int i = 0; i < (1 << LOGN); i++) mem[i] = 32'd0;
    endtask

    task automatic pulse_start();
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
    endtask

    task automatic run_scan();
        pulse_start();
        repeat (DONE_EDGE + 3) @(negedge clk);
        #1;
    endtask

    task automatic load_five();
        clear_mem();
        mem[3]   = {16'd100, 16'd0};
        mem[50]  = {16'd500, 16'd0};
        mem[100] = {16'd300, 16'd0};
        mem[200] = {16'd400, 16'd0};
        mem[250] = {16'd200, 16'd0};
    endtask

    task automatic check_five(input string tag);
        check({tag, "_bin0"}, peak0_bin, 50);
        check({tag, "_bin1"}, peak1_bin, 200);
        check({tag, "_bin2"}, peak2_bin, 100);
        check({tag, "_bin3"}, peak3_bin, 250);
        check({tag, "_mag0"}, peak0_mag, 250000);
        check({tag, "_mag1"}, peak1_mag, 160000);
        check({tag, "_mag2"}, peak2_mag, 90000);
        check({tag, "_mag3"}, peak3_mag, 40000);
        check({tag, "_valid"}, peak_valid, 4'b1111);
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);

        mem[10] = {16'h4000, 16'h0000};
        run_scan();
        check("tone_bin0", peak0_bin, 10);
        check("tone_mag0", peak0_mag, 32'h1000_0000);
        check("tone_valid", peak_valid, 4'b0001);
        check("tone_done", done, 1'b1);

        load_five();
        run_scan();
        check_five("five");

        clear_mem();
        mem[20]  = {16'd1000, 16'd0};
        mem[40]  = {16'd1000, 16'd0};
        mem[0]   = {16'd32767, 16'd0};
        mem[300] = {16'd32767, 16'd0};
        run_scan();
        check("tie_bin0", peak0_bin, 20);
        check("tie_bin1", peak1_bin, 40);
        check("tie_valid", peak_valid, 4'b0011);

        clear_mem();
        mem[7]   = 32'h8000_8000;
        mem[8]   = 32'hFFFF_0001;
        mem[255] = 32'h0003_FFFC;
        run_scan();
        check("max_mag0", peak0_mag, 32'h8000_0000);
        check("max_bin1", peak1_bin, 255);
        check("max_mag1", peak1_mag, 25);
        check("max_mag2", peak2_mag, 2);

        clear_mem();
        run_scan();
        check("zero_valid", peak_valid, 4'b0000);
        check("zero_bin0", peak0_bin, 0);
        check("zero_mag0", peak0_mag, 0);

        load_five();
        pulse_start();
        repeat (100) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_busy", busy, 1'b0);
        check("async_addr", rd_addr, 0);
        check("async_valid", peak_valid, 4'b0000);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("post_rst_addr", rd_addr, 0);
        check("post_rst_done", done, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        pulse_start();
        repeat (8) @(negedge clk);
        pulse_start();
        repeat (138) @(negedge clk);
        pulse_start();
        repeat (DONE_EDGE - 145) @(negedge clk);
        #1;
        check_five("ignore");

        for (int r = 0; r < 4; r++) begin
            clear_mem();
            for (int n = 0; n < 24; n++) begin
                int a = $urandom_range(0, (1 << LOGN) - 1);
                if (r[0]) mem[a] = {16'($urandom_range(0, 6) * 100), 16'($urandom_range(0, 2))};
                else      mem[a] = $urandom;
            end
            run_scan();
        end

        #1 start = 1'b1;
        repeat (2 * DONE_EDGE + 20) @(negedge clk);
        #1 start = 1'b0;
        repeat (DONE_EDGE + 5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
